// File: rtl/plb_mem_slave.sv
// PLB doubleword memory slave: single-beat and burst reads/writes into a 2^ADDR_WIDTH x 64 array.
// Latency: mAddrAck 1 cycle after request, first mRdDAck RD_LATENCY cycles after mAddrAck, write beats from the next cycle.
// Backpressure: requests wait in IDLE until the previous transfer ends; bursts end on master release or MAX_BURST (BTerm).
module plb_mem_slave #(
  parameter int          ADDR_WIDTH = 10,
  parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
  parameter int          RD_LATENCY = 2,
  parameter int          MAX_BURST  = 16
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [31:0] mABus,
  input  logic [7:0]  mBE,
  input  logic        mRNW,
  input  logic        mRequest,
  input  logic [3:0]  mSize,
  input  logic        mRdBurst,
  input  logic        mWrBurst,
  input  logic [63:0] mWrDBus,
  output logic        mAddrAck,
  output logic        mRdDAck,
  output logic        mWrDAck,
  output logic [63:0] mRdDBus,
  output logic [2:0]  mRdWdAddr,
  output logic        mRdBTerm,
  output logic        mWrBTerm,
  output logic        mBusy,
  output logic        mErr
);

  typedef enum logic [1:0] {IDLE, RD_WAIT, RD_DATA, WR_DATA} state_t;

  localparam logic [31:0] winMask  = ~((32'd1 << (ADDR_WIDTH + 3)) - 32'd1);
  localparam logic [3:0]  lastBeat = 4'(MAX_BURST - 1);
  localparam logic [3:0]  waitLast = 4'(RD_LATENCY - 1);

  state_t                state, stateNxt;
  logic [63:0]           mem [0:(1 << ADDR_WIDTH) - 1];
  logic [ADDR_WIDTH-1:0] idx;
  logic                  burst;
  logic [3:0]            beatCnt, beatNext, waitCnt;

  logic inWindow, sizeOk, accept;
  logic rdStart, rdBeat, rdLast, wrStart, wrBeat, wrLast;
  logic addrAckNxt, errNxt, busyNxt, rdAckNxt, rdBTermNxt, wrAckNxt, wrBTermNxt;
  logic [63:0] rdDataNxt;
  logic [2:0]  rdWdAddrNxt;

  // The ack register blocks re-acceptance of the still-held request in the ack cycle of an error response.
  assign inWindow = (mABus & winMask) == BASE_ADDR;
  assign sizeOk   = (mSize == 4'b0000) || (mSize == 4'b1011);
  assign accept   = (state == IDLE) && mRequest && inWindow && !mAddrAck;

  // A beat is in progress whenever its registered data-ack is showing.
  assign rdStart  = (state == RD_WAIT) && (waitCnt == waitLast);
  assign rdBeat   = (state == RD_DATA) && mRdDAck;
  assign rdLast   = !burst || !mRdBurst || (beatCnt == lastBeat);
  assign wrStart  = (state == WR_DATA) && !mWrDAck;
  assign wrBeat   = (state == WR_DATA) && mWrDAck;
  assign wrLast   = !burst || !mWrBurst || (beatCnt == lastBeat);
  assign beatNext = (rdStart || wrStart) ? 4'd0 : beatCnt + 4'd1;

  // State register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    else        state <= stateNxt;
  end

  // Next-state selection.
  always_comb begin
    stateNxt = state;
    case (state)
      IDLE:    if (accept && sizeOk) stateNxt = mRNW ? RD_WAIT : WR_DATA;
      RD_WAIT: if (rdStart) stateNxt = RD_DATA;
      RD_DATA: if (rdBeat && rdLast) stateNxt = IDLE;
      WR_DATA: if (wrBeat && wrLast) stateNxt = IDLE;
      default: stateNxt = IDLE;
    endcase
  end

  // Next values of the registered bus outputs; read data is zero whenever no beat is presented.
  always_comb begin
    addrAckNxt  = accept;
    errNxt      = accept && !sizeOk;
    busyNxt     = accept || (stateNxt != IDLE);
    rdAckNxt    = rdStart || (rdBeat && !rdLast);
    wrAckNxt    = wrStart || (wrBeat && !wrLast);
    rdDataNxt   = 64'd0;
    rdWdAddrNxt = 3'd0;
    rdBTermNxt  = 1'b0;
    wrBTermNxt  = 1'b0;
    if (rdAckNxt) begin
      rdDataNxt   = mem[idx];
      rdWdAddrNxt = beatNext[2:0];
      rdBTermNxt  = burst && (beatNext == lastBeat);
    end
    if (wrAckNxt) wrBTermNxt = burst && (beatNext == lastBeat);
  end

  // Output registers plus index, burst flag and counters; idx is the next read index or the current write index.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      mAddrAck  <= 1'b0;
      mErr      <= 1'b0;
      mBusy     <= 1'b0;
      mRdDAck   <= 1'b0;
      mWrDAck   <= 1'b0;
      mRdDBus   <= 64'd0;
      mRdWdAddr <= 3'd0;
      mRdBTerm  <= 1'b0;
      mWrBTerm  <= 1'b0;
      idx       <= '0;
      burst     <= 1'b0;
      beatCnt   <= 4'd0;
      waitCnt   <= 4'd0;
    end else begin
      mAddrAck  <= addrAckNxt;
      mErr      <= errNxt;
      mBusy     <= busyNxt;
      mRdDAck   <= rdAckNxt;
      mWrDAck   <= wrAckNxt;
      mRdDBus   <= rdDataNxt;
      mRdWdAddr <= rdWdAddrNxt;
      mRdBTerm  <= rdBTermNxt;
      mWrBTerm  <= wrBTermNxt;
      if (accept) begin
        idx   <= mABus[ADDR_WIDTH+2:3];
        burst <= (mSize == 4'b1011);
      end else if (rdAckNxt || wrBeat) begin
        idx <= idx + 1'b1;
      end
      if (rdAckNxt || wrAckNxt) beatCnt <= beatNext;
      if (state == RD_WAIT) waitCnt <= waitCnt + 4'd1;
      else                  waitCnt <= 4'd0;
    end
  end

  // Byte-enabled memory write at the end of each write beat; contents survive reset.
  always_ff @(posedge CLK) begin
    if (wrBeat) begin
      for (int b = 0; b < 8; b++) begin
        if (mBE[b]) mem[idx][8*b +: 8] <= mWrDBus[8*b +: 8];
      end
    end
  end

endmodule

// File: doc/plb_mem_slave.md
PLB_MEM_SLAVE -- requirements
Module: plb_mem_slave

Interface
REQ-001 Parameter ADDR_WIDTH, default 10, doubleword-index width; memory depth 2^ADDR_WIDTH x 64 bits.
REQ-002 Parameter BASE_ADDR, default 32'h8000_0000, aligned window base; window size 2^(ADDR_WIDTH+3) bytes.
REQ-003 Parameter RD_LATENCY, default 2, cycles from mAddrAck to first mRdDAck; legal range 1..15.
REQ-004 Parameter MAX_BURST, default 16, maximum beats per burst; legal range 2..16.
REQ-005 Clocking: one clock; reset is asynchronous and active-low. Clock port CLK; reset port RST_N.
REQ-006 CLK  in  1  sole clock; all state changes on rising edge.
REQ-007 RST_N  in  1  asynchronous active-low reset.
REQ-008 mABus  in  32  request byte address.
REQ-009 mBE  in  8  write byte enables; bit i enables byte i of mWrDBus.
REQ-010 mRNW  in  1  1 = read, 0 = write.
REQ-011 mRequest  in  1  master request, held until mAddrAck.
REQ-012 mSize  in  4  4'b0000 = single beat, 4'b1011 = doubleword burst; all others unsupported.
REQ-013 mRdBurst / mWrBurst  in  1 each  master burst continuation.
REQ-014 mWrDBus  in  64  write data.
REQ-015 mAddrAck  out  1  address-phase acknowledge pulse.
REQ-016 mRdDAck / mWrDAck  out  1 each  per-beat data acknowledge.
REQ-017 mRdDBus  out  64  read data, valid only with mRdDAck, zero otherwise.
REQ-018 mRdWdAddr  out  3  beat index [2:0] within burst, valid with mRdDAck.
REQ-019 mRdBTerm / mWrBTerm  out  1 each  slave burst terminate.
REQ-020 mBusy  out  1  transaction in progress.
REQ-021 mErr  out  1  error pulse for unsupported mSize.

Function
REQ-022 States: IDLE, RD_WAIT, RD_DATA, WR_DATA; registered outputs, no combinational input-to-output paths.
REQ-023 IDLE: mRequest=1 with mABus inside window -> mAddrAck=1 next cycle for one cycle; latch index mABus[ADDR_WIDTH+2:3], mRNW, burst=(mSize==4'b1011).
REQ-024 mRequest outside window -> no response, stay IDLE.
REQ-025 Unsupported mSize in window -> mAddrAck and mErr together one cycle, no data phase, return to IDLE.
REQ-026 After read ack: RD_WAIT counts RD_LATENCY-1 cycles, then RD_DATA; first mRdDAck exactly RD_LATENCY cycles after mAddrAck.
REQ-027 RD_DATA: each cycle one beat, mRdDAck=1, mRdDBus=mem[idx], mRdWdAddr=beat count[2:0]; idx increments modulo 2^ADDR_WIDTH (wraps silently).
REQ-028 Read beat is last when single-beat, or mRdBurst=0 sampled that cycle, or beat count = MAX_BURST-1; at count MAX_BURST-1 with mRdBurst=1, mRdBTerm=1 with that beat.
REQ-029 After write ack: WR_DATA from next cycle; each cycle mWrDAck=1, mem[idx] updated byte-wise per mBE, idx increments with wrap.
REQ-030 Write last-beat rule identical to REQ-028 using mWrBurst/mWrBTerm.
REQ-031 mBusy=1 from mAddrAck cycle through last data beat inclusive; 0 in IDLE.
REQ-032 After last beat return to IDLE; new mRequest accepted earliest cycle after last beat (no ack during busy, request held).
REQ-033 Read-after-write to same index returns newly written data.

Reset
REQ-034 RST_N=0 -> IDLE, counters 0, all outputs 0 immediately (asynchronous); memory contents undefined, not cleared.
REQ-035 Reset mid-transaction aborts it; no further acks after RST_N deasserts until a new mRequest.

Verification
REQ-036 Single write 0xDEADBEEF_01234567 to BASE+0x10, mBE=8'hFF, then single read -> mAddrAck each, read mRdDAck RD_LATENCY=2 cycles after ack, data matches.
REQ-037 Write burst 4 beats at BASE+0x0 (mWrBurst low on beat 4) -> 4 mWrDAck, no mWrBTerm; read burst 4 -> data 0..3, mRdWdAddr 0,1,2,3.
REQ-038 Read burst with mRdBurst held high -> exactly 16 beats, mRdBTerm on 16th, mBusy low next cycle.
REQ-039 Burst starting at last index (2^10-1) -> second beat from index 0 (wrap).
REQ-040 mSize=4'b0001 in window -> mAddrAck+mErr one cycle, no data ack; address outside window -> no ack after 20 cycles.
REQ-041 RST_N low during beat 3 of write burst -> all outputs 0 same cycle, no acks after release; partial mBE=8'h0F write alters only low 4 bytes.
